branch_predictor: RTL and testbench

Dynamic branch predictor feeding the fetch stage of riscv32. It takes the fetch PC and returns the predicted next PC (PPC) in the same cycle. Prediction uses a direct-mapped BHT of 2-bit saturating counters plus a direct-mapped tagged BTB. Both tables are trained from ID-stage branch resolution (ID_PCSrc / ID_BR_PC), and the block reports mispredicts plus running statistics.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: 2-bit counter BHT plus tagged BTB, trained
// from ID-stage resolution, with registered mispredict redirect and saturating stats.
module branch_predictor #(
    parameter int         IDX_W    = 4,
    parameter int         CNT_W    = 16,
    parameter logic [1:0] BHT_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    output logic             pred_btb_hit,
    output logic [31:0]      pred_next_pc,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_pred_taken,
    input  logic [31:0]      upd_pred_next_pc,
    output logic             mispredict,
    output logic [31:0]      correct_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {COUNTING, SATURATED} stat_state_t;

    logic [1:0]       bht        [ENTRIES];
    logic [ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [31:0]      btb_target [ENTRIES];

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic [31:0]      actual_next_pc;
    logic             upd_mispredict;
    stat_state_t      branch_state;
    stat_state_t      mispredict_state;

    // The carried prediction bit is implied by upd_pred_next_pc; pc[1:0] never matters.
    logic unused_bits;
    assign unused_bits = ^{upd_pred_taken, lookup_pc[1:0], upd_pc[1:0]};

    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : cnt + 2'd1;
        else
            return (cnt == 2'b00) ? cnt : cnt - 2'd1;
    endfunction

    assign lookup_idx   = lookup_pc[IDX_W+1:2];
    assign lookup_tag   = lookup_pc[31:IDX_W+2];
    assign pred_btb_hit = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
    assign pred_taken   = bht[lookup_idx][1] && pred_btb_hit;
    assign pred_next_pc = pred_taken ? btb_target[lookup_idx] : lookup_pc + 32'd4;

    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign upd_tag        = upd_pc[31:IDX_W+2];
    assign actual_next_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    assign upd_mispredict = upd_valid && (actual_next_pc != upd_pred_next_pc);

    // Table training; lookups in the same cycle still see the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                bht[i]        <= BHT_INIT;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (upd_valid) begin
            bht[upd_idx] <= bht_next(bht[upd_idx], upd_taken);
            if (upd_taken) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= upd_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict <= 1'b0;
            correct_pc <= '0;
        end else begin
            mispredict <= upd_mispredict;
            if (upd_mispredict)
                correct_pc <= actual_next_pc;
        end
    end

    // Once a counter reaches all-ones it parks in SATURATED until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_state     <= COUNTING;
            mispredict_state <= COUNTING;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            case (branch_state)
                COUNTING: begin
                    if (branch_count == CNT_MAX)
                        branch_state <= SATURATED;
                    else if (upd_valid)
                        branch_count <= branch_count + CNT_ONE;
                end
                SATURATED: branch_state <= SATURATED;
            endcase
            case (mispredict_state)
                COUNTING: begin
                    if (mispredict_count == CNT_MAX)
                        mispredict_state <= SATURATED;
                    else if (upd_mispredict)
                        mispredict_count <= mispredict_count + CNT_ONE;
                end
                SATURATED: mispredict_state <= SATURATED;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a default instance plus a CNT_W=2 instance
// sharing the same stimulus for counter saturation.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_next_pc;

    logic        pred_taken, pred_btb_hit, mispredict;
    logic [31:0] pred_next_pc, correct_pc;
    logic [15:0] branch_count, mispredict_count;

    logic        s_pred_taken, s_pred_btb_hit, s_mispredict;
    logic [31:0] s_pred_next_pc, s_correct_pc;
    logic [1:0]  s_branch_count, s_mispredict_count;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(4), .CNT_W(16), .BHT_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_taken(pred_taken), .pred_btb_hit(pred_btb_hit), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
        .mispredict(mispredict), .correct_pc(correct_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_predictor #(.IDX_W(4), .CNT_W(2), .BHT_INIT(2'b01)) dut_small (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_taken(s_pred_taken), .pred_btb_hit(s_pred_btb_hit), .pred_next_pc(s_pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_next_pc(upd_pred_next_pc),
        .mispredict(s_mispredict), .correct_pc(s_correct_pc),
        .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
    );

    // Drives one update for a single cycle; returns at the negedge after the capturing edge.
    task automatic do_update(input logic [31:0] pc, input logic taken,
                             input logic [31:0] target, input logic [31:0] ppc);
        upd_valid        = 1'b1;
        upd_pc           = pc;
        upd_taken        = taken;
        upd_target       = target;
        upd_pred_next_pc = ppc;
        upd_pred_taken   = (ppc != pc + 32'd4);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        lookup_pc = 32'h8;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_next_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken got %0h required 0", pred_taken); else passed++;
        checks++; if (pred_btb_hit !== 1'b0) $display("FAIL reset_btb_hit got %0h required 0", pred_btb_hit); else passed++;
        checks++; if (pred_next_pc !== 32'hC) $display("FAIL reset_next_pc got %h required 0000000c", pred_next_pc); else passed++;
        checks++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict got %0h required 0", mispredict); else passed++;
        checks++; if (correct_pc !== 32'h0) $display("FAIL reset_correct_pc got %h required 0", correct_pc); else passed++;
        checks++; if (branch_count !== 16'd0) $display("FAIL reset_branch_count got %0d required 0", branch_count); else passed++;
        checks++; if (mispredict_count !== 16'd0) $display("FAIL reset_mispredict_count got %0d required 0", mispredict_count); else passed++;
    endtask

    task automatic test_train;
        @(negedge clk);
        do_update(32'h8, 1'b1, 32'h18, 32'hC);
        lookup_pc = 32'h8;
        #1;
        checks++; if (mispredict !== 1'b1) $display("FAIL train_mispredict got %0h required 1", mispredict); else passed++;
        checks++; if (correct_pc !== 32'h18) $display("FAIL train_correct_pc got %h required 00000018", correct_pc); else passed++;
        checks++; if (pred_taken !== 1'b1) $display("FAIL train_pred_taken got %0h required 1", pred_taken); else passed++;
        checks++; if (pred_next_pc !== 32'h18) $display("FAIL train_next_pc got %h required 00000018", pred_next_pc); else passed++;
        checks++; if (branch_count !== 16'd1) $display("FAIL train_branch_count got %0d required 1", branch_count); else passed++;
        checks++; if (mispredict_count !== 16'd1) $display("FAIL train_mispredict_count got %0d required 1", mispredict_count); else passed++;
        @(negedge clk);
        checks++; if (mispredict !== 1'b0) $display("FAIL train_pulse_end got %0h required 0", mispredict); else passed++;
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 4; i++) begin
            do_update(32'h8, 1'b1, 32'h18, 32'h18);
            checks++; if (mispredict !== 1'b0) $display("FAIL sat_correct_pred%0d got %0h required 0", i, mispredict); else passed++;
        end
        checks++; if (branch_count !== 16'd5) $display("FAIL sat_branch_count got %0d required 5", branch_count); else passed++;
        checks++; if (mispredict_count !== 16'd1) $display("FAIL sat_mispredict_count got %0d required 1", mispredict_count); else passed++;
        // Counter 11 -> 10 -> 01; both still predicted taken, so both mispredict.
        do_update(32'h8, 1'b0, 32'h18, 32'h18);
        do_update(32'h8, 1'b0, 32'h18, 32'h18);
        lookup_pc = 32'h8;
        #1;
        checks++; if (pred_btb_hit !== 1'b1) $display("FAIL nt_btb_hit got %0h required 1", pred_btb_hit); else passed++;
        checks++; if (pred_taken !== 1'b0) $display("FAIL nt_pred_taken got %0h required 0", pred_taken); else passed++;
        checks++; if (pred_next_pc !== 32'hC) $display("FAIL nt_next_pc got %h required 0000000c", pred_next_pc); else passed++;
        checks++; if (branch_count !== 16'd7) $display("FAIL nt_branch_count got %0d required 7", branch_count); else passed++;
        checks++; if (mispredict_count !== 16'd3) $display("FAIL nt_mispredict_count got %0d required 3", mispredict_count); else passed++;
        // 01 + one taken = 10 (taken); a floor at 00 would give 01 (not taken).
        @(negedge clk);
        do_update(32'h8, 1'b1, 32'h18, 32'hC);
        #1;
        checks++; if (pred_taken !== 1'b1) $display("FAIL retrain_pred_taken got %0h required 1", pred_taken); else passed++;
        checks++; if (pred_next_pc !== 32'h18) $display("FAIL retrain_next_pc got %h required 00000018", pred_next_pc); else passed++;
        checks++; if (mispredict_count !== 16'd4) $display("FAIL retrain_mispredict_count got %0d required 4", mispredict_count); else passed++;
    endtask

    task automatic test_alias;
        lookup_pc = 32'h48;
        #1;
        checks++; if (pred_btb_hit !== 1'b0) $display("FAIL alias_btb_hit got %0h required 0", pred_btb_hit); else passed++;
        checks++; if (pred_taken !== 1'b0) $display("FAIL alias_pred_taken got %0h required 0", pred_taken); else passed++;
        checks++; if (pred_next_pc !== 32'h4C) $display("FAIL alias_next_pc got %h required 0000004c", pred_next_pc); else passed++;
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        lookup_pc = 32'h18;
        upd_valid = 1'b1; upd_pc = 32'h18; upd_taken = 1'b1; upd_target = 32'h28;
        upd_pred_taken = 1'b0; upd_pred_next_pc = 32'h1C;
        #1;
        checks++; if (pred_next_pc !== 32'h1C) $display("FAIL same_cycle_old got %h required 0000001c", pred_next_pc); else passed++;
        @(negedge clk);
        upd_valid = 1'b0;
        #1;
        checks++; if (pred_next_pc !== 32'h28) $display("FAIL same_cycle_new got %h required 00000028", pred_next_pc); else passed++;
        checks++; if (correct_pc !== 32'h28) $display("FAIL same_cycle_correct_pc got %h required 00000028", correct_pc); else passed++;
        checks++; if (branch_count !== 16'd9) $display("FAIL same_cycle_branch_count got %0d required 9", branch_count); else passed++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h100;
        upd_pred_taken = 1'b0; upd_pred_next_pc = 32'h24;
        @(negedge clk);
        checks++; if (mispredict !== 1'b1) $display("FAIL b2b_first_mispredict got %0h required 1", mispredict); else passed++;
        checks++; if (correct_pc !== 32'h100) $display("FAIL b2b_first_correct_pc got %h required 00000100", correct_pc); else passed++;
        upd_pc = 32'h30; upd_taken = 1'b0; upd_target = 32'h500; upd_pred_next_pc = 32'h34;
        @(negedge clk);
        upd_valid = 1'b0;
        checks++; if (mispredict !== 1'b0) $display("FAIL b2b_second_mispredict got %0h required 0", mispredict); else passed++;
        checks++; if (branch_count !== 16'd11) $display("FAIL b2b_branch_count got %0d required 11", branch_count); else passed++;
        checks++; if (mispredict_count !== 16'd6) $display("FAIL b2b_mispredict_count got %0d required 6", mispredict_count); else passed++;
    endtask

    task automatic test_async_reset;
        do_update(32'h20, 1'b1, 32'h200, 32'h24);
        checks++; if (mispredict !== 1'b1) $display("FAIL pre_rst_mispredict got %0h required 1", mispredict); else passed++;
        checks++; if (correct_pc !== 32'h200) $display("FAIL pre_rst_correct_pc got %h required 00000200", correct_pc); else passed++;
        upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1; upd_target = 32'h300;
        upd_pred_taken = 1'b0; upd_pred_next_pc = 32'h4C;
        lookup_pc = 32'h8;
        #2 rst = 1'b1;
        #1;
        checks++; if (mispredict !== 1'b0) $display("FAIL async_mispredict got %0h required 0", mispredict); else passed++;
        checks++; if (correct_pc !== 32'h0) $display("FAIL async_correct_pc got %h required 0", correct_pc); else passed++;
        checks++; if (branch_count !== 16'd0) $display("FAIL async_branch_count got %0d required 0", branch_count); else passed++;
        checks++; if (mispredict_count !== 16'd0) $display("FAIL async_mispredict_count got %0d required 0", mispredict_count); else passed++;
        checks++; if (pred_next_pc !== 32'hC) $display("FAIL async_lookup_8 got %h required 0000000c", pred_next_pc); else passed++;
        @(negedge clk);
        upd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        lookup_pc = 32'h48;
        #1;
        checks++; if (pred_btb_hit !== 1'b0) $display("FAIL async_pending_dropped got %0h required 0", pred_btb_hit); else passed++;
        lookup_pc = 32'h18;
        #1;
        checks++; if (pred_next_pc !== 32'h1C) $display("FAIL async_table_cleared got %h required 0000001c", pred_next_pc); else passed++;
        checks++; if (branch_count !== 16'd0) $display("FAIL async_after_branch_count got %0d required 0", branch_count); else passed++;
    endtask

    task automatic test_count_saturation;
        for (int i = 0; i < 5; i++) begin
            do_update(32'h40, 1'b0, 32'h0, 32'h99);
            if (i == 2) begin
                checks++; if (s_mispredict_count !== 2'd3) $display("FAIL small_count_at3 got %0d required 3", s_mispredict_count); else passed++;
            end
        end
        checks++; if (s_mispredict_count !== 2'd3) $display("FAIL small_mispredict_hold got %0d required 3", s_mispredict_count); else passed++;
        checks++; if (s_branch_count !== 2'd3) $display("FAIL small_branch_hold got %0d required 3", s_branch_count); else passed++;
        checks++; if (s_mispredict !== 1'b1) $display("FAIL small_mispredict_pulse got %0h required 1", s_mispredict); else passed++;
        checks++; if (mispredict_count !== 16'd5) $display("FAIL wide_mispredict_count got %0d required 5", mispredict_count); else passed++;
        checks++; if (branch_count !== 16'd5) $display("FAIL wide_branch_count got %0d required 5", branch_count); else passed++;
    endtask

    initial begin
        test_reset;
        test_train;
        test_saturate;
        test_alias;
        test_same_cycle;
        test_back_to_back;
        test_async_reset;
        test_count_saturation;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
